// File: rtl/video_monitor.sv
// video_monitor: receiving end of the PPU video output. Recovers line/frame timing from the
// pixel strobe and sync lines, counts total and active pixels/lines, runs a CRC-16-CCITT over
// active pixels of each frame, and exposes the results as byte registers on a host port.
//
// Ports:
//   I_clock, I_reset      clock, synchronous active-high reset
//   I_vid_rise            one-clock pixel strobe; video inputs sampled only when high
//   I_vid_blank           1 = blanking, 0 = active pixel
//   I_vid_hsync/vsync     sync lines, active level set by P_hsync_pol / P_vsync_pol
//   I_vid_red/green/blue  8-bit pixel colour
//   I_host_addr/wren/rden/data  register index, write strobe, read strobe, write data
//   O_host_data           read data (combinational from I_host_addr, gated by I_host_rden)
//   O_irq                 registered frame interrupt level (frame_done & irq_en)
module video_monitor #(
  parameter bit          P_hsync_pol = 1'b0,
  parameter bit          P_vsync_pol = 1'b0,
  parameter int unsigned P_cnt_bits  = 12
) (
  input  logic       I_clock,
  input  logic       I_reset,
  input  logic       I_vid_rise,
  input  logic       I_vid_blank,
  input  logic       I_vid_hsync,
  input  logic       I_vid_vsync,
  input  logic [7:0] I_vid_red,
  input  logic [7:0] I_vid_green,
  input  logic [7:0] I_vid_blue,
  input  logic [3:0] I_host_addr,
  input  logic       I_host_wren,
  input  logic       I_host_rden,
  input  logic [7:0] I_host_data,
  output logic [7:0] O_host_data,
  output logic       O_irq
);

  typedef logic [P_cnt_bits-1:0] cnt_t;
  localparam cnt_t CntMax = '1;

  cnt_t pix_cnt_q, pix_cnt_d, act_cnt_q, act_cnt_d;
  cnt_t line_cnt_q, line_cnt_d, line_act_q, line_act_d;
  cnt_t h_total_q, h_total_d, h_active_q, h_active_d;
  cnt_t v_total_q, v_total_d, v_active_q, v_active_d;
  logic [15:0] crc_q, crc_d, crc_out_q, crc_out_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic frame_done_q, frame_done_d, overflow_q, overflow_d;
  logic h_seen_q, h_seen_d, h_valid_q, h_valid_d;
  logic v_seen_q, v_seen_d, v_valid_q, v_valid_d;
  logic hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic enable_q, enable_d, irq_en_q, irq_en_d, irq_q, irq_d;

  logic        hs_act, vs_act, strobe, h_edge, v_edge;
  logic        ctrl_wr, stat_wr, en_rise;
  logic [23:0] pixel;
  logic        unused_bits;

  // CRC-16-CCITT, 24 data bits MSB-first in a single step.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign hs_act  = (I_vid_hsync == P_hsync_pol);
  assign vs_act  = (I_vid_vsync == P_vsync_pol);
  assign strobe  = I_vid_rise & enable_q;
  assign h_edge  = strobe & hs_act & ~hs_prev_q;
  assign v_edge  = strobe & vs_act & ~vs_prev_q;
  assign ctrl_wr = I_host_wren & (I_host_addr == 4'hC);
  assign stat_wr = I_host_wren & (I_host_addr == 4'h0);
  assign en_rise = ctrl_wr & I_host_data[0] & ~enable_q;
  assign pixel   = {I_vid_red, I_vid_green, I_vid_blue};
  assign unused_bits = ^I_host_data[7:3];

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    act_cnt_d    = act_cnt_q;
    line_cnt_d   = line_cnt_q;
    line_act_d   = line_act_q;
    h_total_d    = h_total_q;
    h_active_d   = h_active_q;
    v_total_d    = v_total_q;
    v_active_d   = v_active_q;
    crc_d        = crc_q;
    crc_out_d    = crc_out_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = frame_done_q;
    overflow_d   = overflow_q;
    h_seen_d     = h_seen_q;
    h_valid_d    = h_valid_q;
    v_seen_d     = v_seen_q;
    v_valid_d    = v_valid_q;
    hs_prev_d    = hs_prev_q;
    vs_prev_d    = vs_prev_q;
    enable_d     = enable_q;
    irq_en_d     = irq_en_q;
    irq_d        = frame_done_q & irq_en_q;

    // Clears are applied first so a coincident vsync edge set wins.
    if (stat_wr) begin
      if (I_host_data[0]) frame_done_d = 1'b0;
      if (I_host_data[2]) overflow_d   = 1'b0;
    end
    if (ctrl_wr) begin
      enable_d = I_host_data[0];
      irq_en_d = I_host_data[1];
    end

    if (en_rise) begin
      pix_cnt_d  = '0;
      act_cnt_d  = '0;
      line_cnt_d = '0;
      line_act_d = '0;
      crc_d      = 16'hFFFF;
      h_seen_d   = 1'b0;
      h_valid_d  = 1'b0;
      v_seen_d   = 1'b0;
      v_valid_d  = 1'b0;
      hs_prev_d  = 1'b0;
      vs_prev_d  = 1'b0;
    end else if (strobe) begin
      hs_prev_d = hs_act;
      vs_prev_d = vs_act;
      if (!I_vid_blank) crc_d = crc_step(crc_q, pixel);

      if (h_edge) begin
        // The first edge only marks a line start; totals latch from the second edge on.
        if (h_seen_q) begin
          h_total_d = pix_cnt_q;
          if (act_cnt_q != '0) h_active_d = act_cnt_q;
          h_valid_d = 1'b1;
        end
        h_seen_d  = 1'b1;
        pix_cnt_d = cnt_t'(1);
        act_cnt_d = '0;
        if (line_cnt_q == CntMax) overflow_d = 1'b1;
        else                      line_cnt_d = line_cnt_q + 1'b1;
        if (act_cnt_q != '0 && line_act_q != CntMax) line_act_d = line_act_q + 1'b1;
      end else begin
        if (pix_cnt_q == CntMax) overflow_d = 1'b1;
        else                     pix_cnt_d  = pix_cnt_q + 1'b1;
        if (!I_vid_blank && act_cnt_q != CntMax) act_cnt_d = act_cnt_q + 1'b1;
      end

      // Line counters already include a coincident hsync update.
      if (v_edge) begin
        if (v_seen_q) begin
          v_total_d  = line_cnt_d;
          v_active_d = line_act_d;
          crc_out_d  = crc_q;
          v_valid_d  = 1'b1;
        end
        v_seen_d     = 1'b1;
        line_cnt_d   = '0;
        line_act_d   = '0;
        crc_d        = I_vid_blank ? 16'hFFFF : crc_step(16'hFFFF, pixel);
        frame_cnt_d  = frame_cnt_q + 8'd1;
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      pix_cnt_q    <= '0;
      act_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_act_q   <= '0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      v_total_q    <= '0;
      v_active_q   <= '0;
      crc_q        <= '0;
      crc_out_q    <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      h_seen_q     <= 1'b0;
      h_valid_q    <= 1'b0;
      v_seen_q     <= 1'b0;
      v_valid_q    <= 1'b0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      act_cnt_q    <= act_cnt_d;
      line_cnt_q   <= line_cnt_d;
      line_act_q   <= line_act_d;
      h_total_q    <= h_total_d;
      h_active_q   <= h_active_d;
      v_total_q    <= v_total_d;
      v_active_q   <= v_active_d;
      crc_q        <= crc_d;
      crc_out_q    <= crc_out_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      h_seen_q     <= h_seen_d;
      h_valid_q    <= h_valid_d;
      v_seen_q     <= v_seen_d;
      v_valid_q    <= v_valid_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
    end
  end

  logic [15:0] h_total_w, h_active_w, v_total_w, v_active_w;
  logic [7:0]  rdata;

  assign h_total_w  = 16'(h_total_q);
  assign h_active_w = 16'(h_active_q);
  assign v_total_w  = 16'(v_total_q);
  assign v_active_w = 16'(v_active_q);

  always_comb begin
    rdata = 8'h00;
    case (I_host_addr)
      4'h0: rdata = {4'b0000, v_valid_q, overflow_q, h_valid_q, frame_done_q};
      4'h1: rdata = frame_cnt_q;
      4'h2: rdata = h_total_w[7:0];
      4'h3: rdata = h_total_w[15:8];
      4'h4: rdata = h_active_w[7:0];
      4'h5: rdata = h_active_w[15:8];
      4'h6: rdata = v_total_w[7:0];
      4'h7: rdata = v_total_w[15:8];
      4'h8: rdata = v_active_w[7:0];
      4'h9: rdata = v_active_w[15:8];
      4'hA: rdata = crc_out_q[7:0];
      4'hB: rdata = crc_out_q[15:8];
      4'hC: rdata = {6'b000000, irq_en_q, enable_q};
      default: rdata = 8'h00;
    endcase
  end

  assign O_host_data = I_host_rden ? rdata : 8'h00;
  assign O_irq       = irq_q;

endmodule
